// File: rtl/delay_scheduler.sv
// Round-robin delay scheduler: grants one requester at a time, counts its delay
// in prescaled ticks and pulses done on expiry; abort and reset cancel silently.
module delay_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int TICK_PERIOD = 100000,
  parameter int CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*CNT_W-1:0]   delay_in,
  input  logic                       abort,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] active_id
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(TICK_PERIOD);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     lastWinner_q, lastWinner_d;
  logic [IDW-1:0]     activeId_q, activeId_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [PW-1:0]      prescaler_q, prescaler_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;

  logic [IDW-1:0]     pick;
  logic               pickValid;
  int                 cand;
  logic [IDW-1:0]     candIdx;
  logic [CNT_W-1:0]   loadDelay;
  logic [NUM_REQ-1:0] ownerHot;

  // Search downward so the requester closest after the last winner is kept.
  always_comb begin
    pick      = '0;
    pickValid = 1'b0;
    cand      = 0;
    candIdx   = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = int'(lastWinner_q) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      candIdx = IDW'(cand);
      if (req[candIdx]) begin
        pick      = candIdx;
        pickValid = 1'b1;
      end
    end
  end

  always_comb begin
    loadDelay = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (activeId_q == IDW'(i)) loadDelay = delay_in[i*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lastWinner_q <= IDW'(NUM_REQ - 1);
      activeId_q   <= '0;
      remaining_q  <= '0;
      prescaler_q  <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lastWinner_q <= lastWinner_d;
      activeId_q   <= activeId_d;
      remaining_q  <= remaining_d;
      prescaler_q  <= prescaler_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  // The delay is captured while in LOAD, so later delay_in changes are ignored.
  always_comb begin
    state_d      = state_q;
    lastWinner_d = lastWinner_q;
    activeId_d   = activeId_q;
    remaining_d  = remaining_q;
    prescaler_d  = prescaler_q;
    case (state_q)
      IDLE: begin
        if (pickValid) begin
          state_d      = LOAD;
          lastWinner_d = pick;
          activeId_d   = pick;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          remaining_d = loadDelay;
          prescaler_d = PW'(TICK_PERIOD - 1);
          state_d     = (loadDelay == '0) ? DONE : COUNT;
        end
      end
      COUNT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (prescaler_q == '0) begin
          prescaler_d = PW'(TICK_PERIOD - 1);
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) state_d = DONE;
        end else begin
          prescaler_d = prescaler_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ownerHot = {{(NUM_REQ-1){1'b0}}, 1'b1} << activeId_d;

  // Outputs are decoded from the next state so their flops line up with it.
  always_comb begin
    grant_d = '0;
    done_d  = '0;
    busy_d  = (state_d != IDLE);
    if (state_d == LOAD) grant_d = ownerHot;
    if (state_d == DONE) done_d  = ownerHot;
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign active_id = activeId_q;

endmodule

// File: tb/tb_delay_scheduler.sv
// Scenario bench for delay_scheduler (4 requesters, 4-cycle tick, 8-bit delays);
// expected grant/done timing comes from round-robin order and L + D*TICK + 1.
module tb_delay_scheduler;

  localparam int NUM_REQ = 4;
  localparam int TICK    = 4;
  localparam int CNT_W   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] delay_in;
  logic        abort;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [1:0]  active_id;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int tbLast      = NUM_REQ - 1;

  delay_scheduler #(.NUM_REQ(NUM_REQ), .TICK_PERIOD(TICK), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req(req), .delay_in(delay_in), .abort(abort),
    .grant(grant), .done(done), .busy(busy), .active_id(active_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nextWinner(input logic [3:0] m, input int last);
    int j;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (last + k) % NUM_REQ;
      if (m[j[1:0]]) return j;
    end
    return 0;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Waits (bounded) for the next grant or done pulse; at = -1 on timeout.
  task automatic waitEvent(input bit wantGrant, input int limit, output int at, output logic [3:0] val);
    at  = -1;
    val = 4'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (wantGrant ? (grant != 4'b0) : (done != 4'b0)) begin
        at  = cyc;
        val = wantGrant ? grant : done;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'hF; abort = 1'b1; delay_in = $urandom;
    repeat (3) tick();
    vectors++; if (grant !== 4'b0) begin miscompares++; $display("[TB] FAIL reset_grant got=%b want=0000", grant); end
    vectors++; if (done !== 4'b0) begin miscompares++; $display("[TB] FAIL reset_done got=%b want=0000", done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    vectors++; if (active_id !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_active_id got=%0d want=0", active_id); end
    reset = 1'b0; req = 4'b0; abort = 1'b0; tbLast = NUM_REQ - 1;
    repeat (2) tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_round_robin();
    int at, prevL, w;
    logic [3:0] val, expG;
    prevL = -1;
    delay_in = 32'b0; req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      w = nextWinner(4'hF, tbLast);
      expG = 4'b0001 << w;
      waitEvent(1'b1, 10, at, val);
      vectors++; if (val !== expG) begin miscompares++; $display("[TB] FAIL rr_grant[%0d] got=%b want=%b", k, val, expG); end
      vectors++; if (done !== 4'b0) begin miscompares++; $display("[TB] FAIL rr_exclusive[%0d] done=%b want=0000", k, done); end
      if (k > 0) begin
        vectors++; if (at - prevL !== 3) begin miscompares++; $display("[TB] FAIL rr_spacing[%0d] got=%0d want=3", k, at - prevL); end
      end
      tbLast = w; prevL = at;
      if (k == 4) req = 4'b0;
    end
    waitEvent(1'b0, 5, at, val);
    vectors++; if (at !== prevL + 1 || val !== 4'b0001) begin miscompares++; $display("[TB] FAIL rr_last_done got=%b@%0d want=0001@%0d", val, at, prevL + 1); end
    repeat (2) tick();
  endtask

  task automatic test_single();
    int L;
    logic [3:0] val, expDone;
    logic expBusy;
    delay_in = 32'b0; delay_in[7:0] = 8'd3; req = 4'b0001;
    waitEvent(1'b1, 10, L, val);
    vectors++; if (val !== 4'b0001) begin miscompares++; $display("[TB] FAIL single_grant got=%b want=0001", val); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL single_busy_L got=%b want=1", busy); end
    vectors++; if (active_id !== 2'd0) begin miscompares++; $display("[TB] FAIL single_active_id got=%0d want=0", active_id); end
    req = 4'b0; tbLast = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      expBusy = (c <= 3 * TICK + 1);
      expDone = (c == 3 * TICK + 1) ? 4'b0001 : 4'b0000;
      vectors++; if (busy !== expBusy) begin miscompares++; $display("[TB] FAIL single_busy L+%0d got=%b want=%b", c, busy, expBusy); end
      vectors++; if (done !== expDone) begin miscompares++; $display("[TB] FAIL single_done L+%0d got=%b want=%b", c, done, expDone); end
    end
    tick();
  endtask

  task automatic test_zero_delay();
    int L, at;
    logic [3:0] val;
    delay_in = $urandom; delay_in[23:16] = 8'd0; req = 4'b0100;
    waitEvent(1'b1, 10, L, val);
    vectors++; if (val !== 4'b0100) begin miscompares++; $display("[TB] FAIL zero_grant got=%b want=0100", val); end
    req = 4'b0; tbLast = 2;
    waitEvent(1'b0, 5, at, val);
    vectors++; if (at !== L + 1 || val !== 4'b0100) begin miscompares++; $display("[TB] FAIL zero_done got=%b@%0d want=0100@%0d", val, at, L + 1); end
    vectors++; if (grant !== 4'b0) begin miscompares++; $display("[TB] FAIL zero_exclusive grant=%b want=0000", grant); end
    repeat (2) tick();
  endtask

  task automatic test_abort();
    int L, at;
    logic [3:0] val;
    delay_in = 32'b0; delay_in[7:0] = 8'd5; req = 4'b0001;
    waitEvent(1'b1, 10, L, val);
    vectors++; if (val !== 4'b0001) begin miscompares++; $display("[TB] FAIL abort_grant got=%b want=0001", val); end
    req = 4'b0010; tbLast = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c <= 7) begin
        vectors++; if (done !== 4'b0) begin miscompares++; $display("[TB] FAIL abort_no_done L+%0d got=%b want=0000", c, done); end
      end
      if (c == 6) begin
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_busy_before got=%b want=1", busy); end
        abort = 1'b1;
      end
      if (c == 7) begin
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy_after got=%b want=0", busy); end
        abort = 1'b0;
      end
      if (c == 8) begin
        vectors++; if (grant !== 4'b0010) begin miscompares++; $display("[TB] FAIL abort_pending_grant got=%b want=0010", grant); end
        req = 4'b0; tbLast = 1;
      end
    end
    waitEvent(1'b0, 5, at, val);
    vectors++; if (at !== L + 9 || val !== 4'b0010) begin miscompares++; $display("[TB] FAIL abort_next_done got=%b@%0d want=0010@%0d", val, at, L + 9); end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    int L, at;
    logic [3:0] val, doneSeen;
    doneSeen = 4'b0;
    delay_in = 32'b0; delay_in[7:0] = 8'd10; req = 4'b0001;
    waitEvent(1'b1, 10, L, val);
    vectors++; if (val !== 4'b0001) begin miscompares++; $display("[TB] FAIL rstmid_grant got=%b want=0001", val); end
    req = 4'b0; tbLast = 0;
    for (int c = 1; c <= 50; c++) begin
      tick();
      doneSeen = doneSeen | done;
      if (c == 6) begin
        vectors++; if ({grant, done, busy, active_id} !== 11'b0) begin miscompares++; $display("[TB] FAIL rstmid_outputs got grant=%b done=%b busy=%b id=%0d want all 0", grant, done, busy, active_id); end
        reset = 1'b0;
      end
      if (c == 5) reset = 1'b1;
    end
    vectors++; if (doneSeen !== 4'b0) begin miscompares++; $display("[TB] FAIL rstmid_no_done got=%b want=0000", doneSeen); end
    tbLast = NUM_REQ - 1;
    req = 4'b0001;
    waitEvent(1'b1, 10, L, val);
    vectors++; if (val !== 4'b0001) begin miscompares++; $display("[TB] FAIL rstmid_regrant got=%b want=0001", val); end
    req = 4'b0; tbLast = 0;
    waitEvent(1'b0, 50, at, val);
    vectors++; if (at !== L + 10 * TICK + 1 || val !== 4'b0001) begin miscompares++; $display("[TB] FAIL rstmid_done got=%b@%0d want=0001@%0d", val, at, L + 10 * TICK + 1); end
    repeat (2) tick();
  endtask

  task automatic test_long_delay();
    int L, at;
    logic [3:0] val;
    delay_in = 32'b0; delay_in[15:8] = 8'd255; req = 4'b0010;
    waitEvent(1'b1, 10, L, val);
    vectors++; if (val !== 4'b0010) begin miscompares++; $display("[TB] FAIL long_grant got=%b want=0010", val); end
    req = 4'b0; tbLast = 1;
    repeat (100) tick();
    delay_in = $urandom;
    waitEvent(1'b0, 1000, at, val);
    vectors++; if (at !== L + 255 * TICK + 1 || val !== 4'b0010) begin miscompares++; $display("[TB] FAIL long_done got=%b@%0d want=0010@%0d", val, at, L + 255 * TICK + 1); end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL long_idle_busy got=%b want=0", busy); end
    tick();
  endtask

  task automatic test_random();
    int at, w, expL, expD;
    int dly[4];
    logic [3:0] mask, val, expG;
    for (int t = 0; t < 8; t++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NUM_REQ; i++) begin
        dly[i] = $urandom_range(0, 3);
        delay_in[i*CNT_W +: CNT_W] = 8'(dly[i]);
      end
      tick();
      req  = mask;
      expL = cyc + 1;
      for (int k = 0; k < 4; k++) begin
        w    = nextWinner(mask, tbLast);
        expG = 4'b0001 << w;
        waitEvent(1'b1, 20, at, val);
        vectors++; if (at !== expL || val !== expG) begin miscompares++; $display("[TB] FAIL rand_grant t%0d k%0d got=%b@%0d want=%b@%0d", t, k, val, at, expG, expL); end
        if (k == 3) req = 4'b0;
        tbLast = w;
        expD = expL + dly[w] * TICK + 1;
        waitEvent(1'b0, 20, at, val);
        vectors++; if (at !== expD || val !== expG) begin miscompares++; $display("[TB] FAIL rand_done t%0d k%0d got=%b@%0d want=%b@%0d", t, k, val, at, expG, expD); end
        expL = expD + 2;
      end
      repeat (2) tick();
    end
  endtask

  initial begin
    reset = 1'b1; req = 4'b0; abort = 1'b0; delay_in = 32'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_zero_delay();
    test_abort();
    test_reset_mid();
    test_long_delay();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/delay_scheduler.md
DELAY_SCHEDULER -- requirements
Module: delay_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter TICK_PERIOD, default 100000, meaning clk cycles per tick (>=2).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of each delay value in ticks.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-006 The block SHALL have port req, input, NUM_REQ, where bit i high means requester i wants a delay.
REQ-007 The block SHALL have port delay_in, input, NUM_REQ*CNT_W, where slice i holds requester i's delay in ticks.
REQ-008 The block SHALL have port abort, input, 1, which cancels the active delay.
REQ-009 The block SHALL have port grant, output, NUM_REQ, a one-hot one-cycle acceptance pulse.
REQ-010 The block SHALL have port done, output, NUM_REQ, a one-hot one-cycle expiry pulse.
REQ-011 The block SHALL have port busy, output, 1, which is high in every state except IDLE.
REQ-012 The block SHALL have port active_id, output, $clog2(NUM_REQ), giving the index of the current or last owner.

Function
REQ-013 The block SHALL implement the FSM states IDLE, LOAD, COUNT and DONE; all outputs SHALL be registered.
REQ-014 In IDLE with req!=0, the block SHALL pick a winner round-robin, starting the search at last_winner+1 (mod NUM_REQ), and enter LOAD.
REQ-015 In the LOAD cycle, grant[winner] SHALL be 1, delay_in[winner] SHALL be latched into remaining, and the prescaler SHALL be loaded with TICK_PERIOD-1.
REQ-016 From LOAD, the block SHALL go to DONE if remaining==0, otherwise to COUNT.
REQ-017 In COUNT, the prescaler SHALL decrement each cycle; when it is 0 it SHALL reload with TICK_PERIOD-1 and remaining SHALL decrement (one tick).
REQ-018 When a tick occurs with remaining==1, the block SHALL go to DONE.
REQ-019 In the DONE cycle, done[winner] SHALL be 1, and the next state SHALL be IDLE.
REQ-020 Latency: for LOAD at cycle L and delay D, done SHALL assert at cycle L+D*TICK_PERIOD+1 (D=0 gives L+1).
REQ-021 req SHALL be sampled only in IDLE; a req bit dropped before grant is lost, and req changes during LOAD, COUNT or DONE SHALL be ignored.
REQ-022 The block SHALL ignore delay_in changes after LOAD.
REQ-023 abort high in LOAD or COUNT SHALL force IDLE on the next edge with no done pulse; abort SHALL have no effect in IDLE or DONE.
REQ-024 From DONE or an abort, the block SHALL spend at least one cycle in IDLE, so the minimum spacing between grants is 3 cycles.
REQ-025 A requester still holding req after its done SHALL be granted again only if no other req bit is set at the IDLE evaluation.
REQ-026 remaining SHALL be an unsigned CNT_W-bit value; D=2^CNT_W-1 SHALL count fully without wrap.
REQ-027 grant and done SHALL never be nonzero in the same cycle, and each SHALL have at most one bit set.

Reset
REQ-028 While reset is high, the FSM SHALL be held in IDLE, with grant=0, done=0, busy=0, active_id=0, last_winner=NUM_REQ-1 (so requester 0 wins first), remaining=0 and prescaler=0.
REQ-029 Reset SHALL take priority over abort and req; reset mid-COUNT SHALL drop the delay with no done pulse.

Verification (TICK_PERIOD=4, NUM_REQ=4, CNT_W=8)
REQ-030 Bench: req=0001, delay0=3 -> grant=0001 at L, done=0001 at L+13, busy high L..L+13.
REQ-031 Bench: req=1111 held, all delays=0 -> grants in order 0001,0010,0100,1000,0001, spaced 3 cycles.
REQ-032 Bench: req=0100, delay2=0 -> grant at L, done=0100 at L+1.
REQ-033 Bench: delay0=5, abort pulsed at L+6 -> busy low at L+7, no done; a pending req=0010 is granted at L+8.
REQ-034 Bench: reset pulsed at L+5 during delay0=10 -> all outputs 0 next cycle, no done; after release, req=0001 is granted.
REQ-035 Bench: delay1=255 -> done at L+1021; delay_in changed mid-count -> same timing.
